// File: rtl/csr_arb.sv
// CSR access arbiter: serialises ex and clint CSR requests into atomic
// read / optional write / done sequences on the single csr_reg port.
module csr_arb #(
    parameter bit FAIR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_req_i,
    input  logic [31:0] ex_addr_i,
    input  logic [1:0]  ex_op_i,
    input  logic [31:0] ex_wdata_i,
    output logic        ex_gnt_o,
    output logic        ex_done_o,
    output logic [31:0] ex_rdata_o,
    input  logic        clint_req_i,
    input  logic [31:0] clint_addr_i,
    input  logic [1:0]  clint_op_i,
    input  logic [31:0] clint_wdata_i,
    output logic        clint_gnt_o,
    output logic        clint_done_o,
    output logic [31:0] clint_rdata_o,
    output logic [31:0] csr_raddr_o,
    input  logic [31:0] csr_rdata_i,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        busy_o
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 2;
    localparam logic [OPW-1:0] OP_RW = 2'b01;
    localparam logic [OPW-1:0] OP_RS = 2'b10;
    localparam logic [OPW-1:0] OP_RC = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
    typedef enum logic {OWN_EX, OWN_CLINT} owner_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] wdata;
    } csr_req_t;

    state_e          state_q, state_d;
    owner_e          owner_q, last_q, pick_d;
    csr_req_t        lat_q, ex_req_s, clint_req_s;
    logic [XLEN-1:0] old_q, new_val, ret_val;
    logic            wr_req;

    assign ex_req_s    = '{addr: ex_addr_i,    op: ex_op_i,    wdata: ex_wdata_i};
    assign clint_req_s = '{addr: clint_addr_i, op: clint_op_i, wdata: clint_wdata_i};

    // Set/clear with an all-zero mask leaves the CSR untouched, so skip the write.
    always_comb begin
        wr_req  = (lat_q.op == OP_RW) || (lat_q.op[1] && (lat_q.wdata != '0));
        new_val = lat_q.wdata;
        case (lat_q.op)
            OP_RS:   new_val = old_q | lat_q.wdata;
            OP_RC:   new_val = old_q & ~lat_q.wdata;
            default: new_val = lat_q.wdata;
        endcase
        ret_val = (state_q == READ) ? csr_rdata_i : old_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state, grant/done pulses and CSR port drive.
    always_comb begin
        state_d      = state_q;
        pick_d       = OWN_EX;
        ex_gnt_o     = 1'b0;
        clint_gnt_o  = 1'b0;
        ex_done_o    = 1'b0;
        clint_done_o = 1'b0;
        csr_raddr_o  = '0;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        busy_o       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (rst && (ex_req_i || clint_req_i)) begin
                    // Fair mode hands the slot to ex after a clint grant if ex is waiting.
                    if (clint_req_i && !(FAIR_EN && (last_q == OWN_CLINT) && ex_req_i))
                        pick_d = OWN_CLINT;
                    else
                        pick_d = OWN_EX;
                    ex_gnt_o    = (pick_d == OWN_EX);
                    clint_gnt_o = (pick_d == OWN_CLINT);
                    state_d     = READ;
                end
            end
            READ: begin
                csr_raddr_o = lat_q.addr;
                state_d     = wr_req ? WRITE : DONE;
            end
            WRITE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = lat_q.addr;
                csr_wdata_o = new_val;
                state_d     = DONE;
            end
            DONE: begin
                ex_done_o    = (owner_q == OWN_EX);
                clint_done_o = (owner_q == OWN_CLINT);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Owner/request latch, old-value capture and per-requester return data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q       <= OWN_EX;
            last_q        <= OWN_EX;
            lat_q         <= '0;
            old_q         <= '0;
            ex_rdata_o    <= '0;
            clint_rdata_o <= '0;
        end else begin
            if ((state_q == IDLE) && (state_d == READ)) begin
                owner_q <= pick_d;
                last_q  <= pick_d;
                lat_q   <= (pick_d == OWN_CLINT) ? clint_req_s : ex_req_s;
            end
            if (state_q == READ) old_q <= csr_rdata_i;
            if (state_d == DONE) begin
                if (owner_q == OWN_EX) ex_rdata_o    <= ret_val;
                else                   clint_rdata_o <= ret_val;
            end
        end
    end

endmodule
